// File: rtl/slib_mode_counter_if.sv
// Bus bundle for slib_mode_counter: control/config inputs and registered status outputs.
// The master modport drives control and observes status; the slave is the counter.
interface slib_mode_counter_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PW    = 4
);
  // Control and configuration
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             enable;
  logic             down;
  logic [1:0]       mode;
  logic [WIDTH-1:0] limit;
  logic [PW-1:0]    presc;
  logic             flag_clr;

  // Status
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             overflow;
  logic             underflow;
  logic             done;

  modport master (
    output clear, load, d, enable, down, mode, limit, presc, flag_clr,
    input  q, tc, overflow, underflow, done
  );

  modport slave (
    input  clear, load, d, enable, down, mode, limit, presc, flag_clr,
    output q, tc, overflow, underflow, done
  );
endinterface

// File: rtl/slib_mode_counter.sv
// Up/down counter with programmable limit, enable prescaler, four boundary modes
// (wrap, saturate, one-shot, auto-reload), a terminal-count pulse and sticky
// overflow/underflow flags. All outputs come straight from registers.
module slib_mode_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PW    = 4
) (
  input logic               clk,
  input logic               rstn,
  slib_mode_counter_if.slave bus
);

  typedef enum logic [1:0] {
    ModeWrap    = 2'b00,
    ModeSat     = 2'b01,
    ModeOneShot = 2'b10,
    ModeReload  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             done_q, done_d;

  mode_e mode;
  logic  presc_hit;
  logic  up_bound;
  logic  dn_bound;

  assign mode      = mode_e'(bus.mode);
  assign presc_hit = (pre_q == bus.presc);
  // Bounds are decided only against LIMIT and 0; a loaded value above LIMIT
  // counts as already at the upper bound.
  assign up_bound  = (q_q >= bus.limit);
  assign dn_bound  = (q_q == '0);

  // Next-state: clear > load > prescaled step; flags are sticky with set winning over clear.
  always_comb begin
    q_d    = q_q;
    pre_d  = pre_q;
    tc_d   = 1'b0;
    ovf_d  = ovf_q & ~bus.flag_clr;
    unf_d  = unf_q & ~bus.flag_clr;
    done_d = done_q;

    if (bus.clear) begin
      q_d    = '0;
      pre_d  = '0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
      done_d = 1'b0;
    end else if (bus.load) begin
      q_d    = bus.d;
      pre_d  = '0;
      done_d = 1'b0;
    end else if (bus.enable) begin
      if (!presc_hit) begin
        // A prescaler above a newly lowered PRESC keeps counting and wraps mod 2^PW.
        pre_d = pre_q + 1'b1;
      end else begin
        pre_d = '0;
        // A halted one-shot ignores steps entirely.
        if (!done_q) begin
          if (!bus.down) begin
            if (!up_bound) begin
              q_d = q_q + 1'b1;
            end else begin
              tc_d  = 1'b1;
              ovf_d = 1'b1;
              unique case (mode)
                ModeWrap:    q_d = '0;
                ModeSat:     q_d = q_q;
                ModeOneShot: done_d = 1'b1;
                ModeReload:  q_d = bus.d;
                default:     q_d = q_q;
              endcase
            end
          end else begin
            if (!dn_bound) begin
              q_d = q_q - 1'b1;
            end else begin
              tc_d  = 1'b1;
              unf_d = 1'b1;
              unique case (mode)
                ModeWrap:    q_d = bus.limit;
                ModeSat:     q_d = q_q;
                ModeOneShot: done_d = 1'b1;
                ModeReload:  q_d = bus.d;
                default:     q_d = q_q;
              endcase
            end
          end
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_q    <= '0;
      pre_q  <= '0;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      pre_q  <= pre_d;
      tc_q   <= tc_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      done_q <= done_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.tc        = tc_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_slib_mode_counter.sv
// Directed bench for slib_mode_counter (WIDTH=5, PW=4). Each step pushes the
// expected outputs to a scoreboard queue, clocks once, then pops and compares.
module tb_slib_mode_counter;
  localparam int unsigned WIDTH = 5;
  localparam int unsigned PW    = 4;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;
    logic             unf;
    logic             done;
  } exp_t;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  exp_t sb[$];

  slib_mode_counter_if #(.WIDTH(WIDTH), .PW(PW)) bus ();

  slib_mode_counter #(.WIDTH(WIDTH), .PW(PW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Push expectation, clock once, pop and compare away from the edge.
  task automatic cyc(input string tag, input logic [WIDTH-1:0] q, input logic tc,
                     input logic ovf, input logic unf, input logic done);
    exp_t e;
    exp_t o;
    sb.push_back('{q: q, tc: tc, ovf: ovf, unf: unf, done: done});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    o = '{q: bus.q, tc: bus.tc, ovf: bus.overflow, unf: bus.underflow, done: bus.done};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed q=%0d tc=%b ovf=%b unf=%b done=%b required q=%0d tc=%b ovf=%b unf=%b done=%b",
             tag, o.q, o.tc, o.ovf, o.unf, o.done, e.q, e.tc, e.ovf, e.unf, e.done);
    end
  endtask

  task automatic idle();
    bus.clear    = 1'b0;
    bus.load     = 1'b0;
    bus.enable   = 1'b0;
    bus.flag_clr = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    idle();
    bus.d = '0; bus.down = 1'b0; bus.mode = 2'b00; bus.limit = '0; bus.presc = '0;
    #1;

    // Reset with ENABLE asserted
    bus.enable = 1'b1;
    cyc("rst0", 0, 0, 0, 0, 0);
    cyc("rst1", 0, 0, 0, 0, 0);
    rstn = 1'b1;

    // CLEAR beats LOAD
    bus.enable = 1'b0; bus.clear = 1'b1; bus.load = 1'b1; bus.d = 5;
    cyc("clr_over_load", 0, 0, 0, 0, 0);

    // Wrap up, LIMIT=9
    idle(); bus.mode = 2'b00; bus.limit = 9; bus.presc = 0; bus.down = 1'b0; bus.enable = 1'b1;
    for (int i = 1; i <= 9; i++) cyc("wrap_up", WIDTH'(i), 0, 0, 0, 0);
    cyc("wrap_tc", 0, 1, 1, 0, 0);
    cyc("wrap_1", 1, 0, 1, 0, 0);
    cyc("wrap_2", 2, 0, 1, 0, 0);
    bus.enable = 1'b0;
    cyc("ovf_sticky", 2, 0, 1, 0, 0);
    bus.flag_clr = 1'b1;
    cyc("flag_clr", 2, 0, 0, 0, 0);

    // Prescaler + saturate down
    idle(); bus.mode = 2'b01; bus.load = 1'b1; bus.d = 2;
    cyc("sat_load", 2, 0, 0, 0, 0);
    idle(); bus.presc = 2; bus.down = 1'b1; bus.enable = 1'b1;
    cyc("pre_c1", 2, 0, 0, 0, 0);
    cyc("pre_c2", 2, 0, 0, 0, 0);
    cyc("pre_c3", 1, 0, 0, 0, 0);
    cyc("pre_c4", 1, 0, 0, 0, 0);
    cyc("pre_c5", 1, 0, 0, 0, 0);
    cyc("pre_c6", 0, 0, 0, 0, 0);
    cyc("pre_c7", 0, 0, 0, 0, 0);
    cyc("pre_c8", 0, 0, 0, 0, 0);
    cyc("sat_unf", 0, 1, 0, 1, 0);
    cyc("sat_c10", 0, 0, 0, 1, 0);
    cyc("sat_c11", 0, 0, 0, 1, 0);
    cyc("sat_c12", 0, 1, 0, 1, 0);

    // One-shot up, LIMIT=3
    idle(); bus.clear = 1'b1;
    cyc("os_clear", 0, 0, 0, 0, 0);
    idle(); bus.mode = 2'b10; bus.limit = 3; bus.presc = 0; bus.down = 1'b0; bus.enable = 1'b1;
    cyc("os_1", 1, 0, 0, 0, 0);
    cyc("os_2", 2, 0, 0, 0, 0);
    cyc("os_3", 3, 0, 0, 0, 0);
    cyc("os_done", 3, 1, 1, 0, 1);
    cyc("os_hold1", 3, 0, 1, 0, 1);
    cyc("os_hold2", 3, 0, 1, 0, 1);
    bus.load = 1'b1; bus.d = 0;
    cyc("os_reload", 0, 0, 1, 0, 0);
    bus.load = 1'b0;
    cyc("os_resume", 1, 0, 1, 0, 0);

    // Auto-reload, LIMIT=15, D=12
    idle(); bus.clear = 1'b1;
    cyc("ar_clear", 0, 0, 0, 0, 0);
    idle(); bus.mode = 2'b11; bus.limit = 15; bus.d = 12; bus.load = 1'b1;
    cyc("ar_load", 12, 0, 0, 0, 0);
    idle(); bus.enable = 1'b1;
    cyc("ar_13", 13, 0, 0, 0, 0);
    cyc("ar_14", 14, 0, 0, 0, 0);
    cyc("ar_15", 15, 0, 0, 0, 0);
    cyc("ar_rl1", 12, 1, 1, 0, 0);
    cyc("ar_13b", 13, 0, 1, 0, 0);
    cyc("ar_14b", 14, 0, 1, 0, 0);
    cyc("ar_15b", 15, 0, 1, 0, 0);
    cyc("ar_rl2", 12, 1, 1, 0, 0);

    // Wrap down, LIMIT=4
    idle(); bus.clear = 1'b1;
    cyc("wd_clear", 0, 0, 0, 0, 0);
    idle(); bus.mode = 2'b00; bus.limit = 4; bus.down = 1'b1; bus.enable = 1'b1;
    cyc("wd_to_lim", 4, 1, 0, 1, 0);
    cyc("wd_3", 3, 0, 0, 1, 0);

    // LIMIT=0: every step is a boundary, TC held high
    idle(); bus.clear = 1'b1;
    cyc("l0_clear", 0, 0, 0, 0, 0);
    idle(); bus.limit = 0; bus.down = 1'b0; bus.enable = 1'b1;
    cyc("l0_a", 0, 1, 1, 0, 0);
    cyc("l0_b", 0, 1, 1, 0, 0);
    cyc("l0_c", 0, 1, 1, 0, 0);

    // Flag set beats FLAG_CLR in the same cycle
    idle(); bus.clear = 1'b1;
    cyc("sim_clear", 0, 0, 0, 0, 0);
    idle(); bus.limit = 1; bus.enable = 1'b1;
    cyc("sim_1", 1, 0, 0, 0, 0);
    bus.flag_clr = 1'b1;
    cyc("set_beats_clr", 0, 1, 1, 0, 0);
    bus.enable = 1'b0;
    cyc("clr_alone", 0, 0, 0, 0, 0);

    // Load above LIMIT, then step up wraps to 0
    idle(); bus.limit = 10; bus.d = 20; bus.load = 1'b1;
    cyc("ld_above", 20, 0, 0, 0, 0);
    idle(); bus.enable = 1'b1;
    cyc("above_wrap", 0, 1, 1, 0, 0);

    // Load above LIMIT, counting down decrements normally
    idle(); bus.load = 1'b1;
    cyc("ld_above2", 20, 0, 1, 0, 0);
    idle(); bus.down = 1'b1; bus.enable = 1'b1;
    cyc("above_down", 19, 0, 1, 0, 0);

    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/slib_mode_counter.md
# slib_mode_counter

Parametrised up/down counter for the APB UART support library and other low-speed peripherals that need programmable timing. It adds a programmable terminal value (`LIMIT`), an enable prescaler, four boundary modes (wrap, saturate, one-shot, auto-reload), a one-cycle terminal-count pulse and sticky overflow/underflow flags. It replaces hand-built divider/timeout logic around plain counters in baud, character-timeout and FIFO-level paths.

## Interface
- `WIDTH`, 4: counter, `D` and `LIMIT` width (≥2).
- `PW`, 4: prescaler width (≥1).
- `CLK` in 1: clock, rising edge.
- `RSTN` in 1: reset, synchronous, active-low.
- `CLEAR` in 1: synchronous clear of count, prescaler, flags and DONE.
- `LOAD` in 1: load `D` into count.
- `D` in WIDTH: load value; also the reload value in mode 11.
- `ENABLE` in 1: count request; qualified by the prescaler.
- `DOWN` in 1: 0 = count up, 1 = count down; sampled at each step.
- `MODE` in 2: 00 wrap, 01 saturate, 10 one-shot, 11 auto-reload.
- `LIMIT` in WIDTH: upper bound; the lower bound is fixed at 0.
- `PRESC` in PW: step every `PRESC`+1 enabled cycles.
- `FLAG_CLR` in 1: clears OVERFLOW and UNDERFLOW.
- `Q` out WIDTH: count value.
- `TC` out 1: terminal-count pulse, one cycle.
- `OVERFLOW` out 1: sticky; set on an up boundary event.
- `UNDERFLOW` out 1: sticky; set on a down boundary event.
- `DONE` out 1: one-shot halted.

## Operation
- Priority per cycle: `RSTN`=0 > `CLEAR` > `LOAD` > step. Lower-priority actions in the same cycle are discarded.
- Reset/CLEAR: Q=0, prescaler=0, TC=0, OVERFLOW=UNDERFLOW=0, DONE=0.
- LOAD:
  - Q=D and prescaler=0.
  - DONE is cleared; sticky flags are kept.
  - TC=0 that cycle.
  - D>LIMIT is allowed.
- Prescaler:
  - In a cycle with ENABLE=1 and no CLEAR/LOAD, if prescaler==PRESC then prescaler←0 and a step occurs; otherwise prescaler+1.
  - ENABLE=0 holds the prescaler.
  - A change to PRESC takes effect on the next compare.
  - A prescaler already above a newly lowered PRESC continues counting up and wraps modulo 2^PW before it matches.
- Step while DONE=1: ignored. Q, TC and the flags do not change.
- Up step, not at bound (Q<LIMIT): Q←Q+1.
- Up step at bound (Q≥LIMIT):
  - wrap: Q←0.
  - saturate: Q unchanged.
  - one-shot: Q unchanged, DONE←1.
  - reload: Q←D.
  - All modes: TC pulse and OVERFLOW←1.
- Down step, not at bound (Q>0): Q←Q−1.
- Down step at bound (Q==0):
  - wrap: Q←LIMIT.
  - saturate: Q unchanged.
  - one-shot: DONE←1.
  - reload: Q←D.
  - All modes: TC pulse and UNDERFLOW←1.
- Q>LIMIT counting down decrements normally toward 0.
- No arithmetic wraps modulo 2^WIDTH; bounds are decided only by LIMIT and 0.
- FLAG_CLR and a flag-setting event in the same cycle: the flag is set.
- MODE change mid-count: the new mode applies from the next step; Q is not adjusted.
- LIMIT=0: every step is a boundary event in both directions.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Q updates on the clock edge that samples the step, load or clear.
- TC:
  - High for exactly the one cycle following the boundary step.
  - Back-to-back boundary steps (PRESC=0, LIMIT=0) hold TC high continuously.
- Flags and DONE update on the same edge as TC.
- ENABLE-to-Q latency: 1 cycle with PRESC=0; otherwise the step happens on the (PRESC+1)-th enabled cycle.
- No combinational input-to-output paths.

## Test plan
- Reset and clear: RSTN=0 for 2 cycles with ENABLE=1 → all outputs 0. Release, then assert CLEAR on the same edge as LOAD with D=5 → Q=0.
- Wrap up: MODE=00, LIMIT=9, PRESC=0, ENABLE=1 for 12 cycles → Q runs 1..9,0,1,2. TC is high for one cycle coincident with Q=0. OVERFLOW stays set until FLAG_CLR.
- Prescaler and saturate down: MODE=01, LOAD D=2, PRESC=2, DOWN=1, ENABLE=1 for 12 cycles → Q=1 after cycle 3, Q=0 after cycle 6. At cycle 9, TC pulses, UNDERFLOW=1 and Q stays 0.
- One-shot: MODE=10, LIMIT=3, count up from 0 → TC and DONE after the step at Q=3. Further enables leave Q=3. LOAD D=0 clears DONE and counting resumes.
- Auto-reload: MODE=11, LIMIT=15, D=12, LOAD, then count up → sequence 13,14,15,12,13. TC pulses at each 15→12 transition.
- Simultaneous events: FLAG_CLR on the cycle of an overflow step → OVERFLOW=1. LOAD D=20 (WIDTH=5) with LIMIT=10, then step up → Q←0 in wrap mode with TC.
